// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider.
//   state_t           : controller state (IDLE, RUN), 1-bit encoding
//   DIV_WIDTH_DEFAULT : default operand width
//   dbz_quotient()    : all-ones quotient reported on a divide-by-zero
package div_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int DIV_WIDTH_DEFAULT = 8;

   // All-ones value of the given width (width 1..32); callers truncate.
   function automatic logic [31:0] dbz_quotient(input int width);
      logic [32:0] full;
      full = (33'd1 << width) - 33'd1;
      return full[31:0];
   endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration (purely combinational).
// Ports:
//   rem          in  WIDTH  partial remainder (always < divisor)
//   dividend_msb in  1      next dividend bit brought down
//   divisor      in  WIDTH  divisor
//   rem_next     out WIDTH  updated partial remainder
//   q_bit        out 1      quotient bit resolved this iteration
module divider_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             dividend_msb,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic             q_bit
);

   // The trial value keeps the bit shifted out of rem, so the compare and
   // subtract are WIDTH+1 bits wide and cannot overflow when the divisor
   // MSB is set.
   logic [WIDTH:0] trial;
   logic [WIDTH:0] divisor_ext;

   always_comb begin
      trial       = {rem, dividend_msb};
      divisor_ext = {1'b0, divisor};
      q_bit       = (trial >= divisor_ext);
      if (q_bit) begin
         rem_next = WIDTH'(trial - divisor_ext);
      end else begin
         rem_next = trial[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/divider_8x8_seq.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk         in  1      rising-edge clock
//   rst_n       in  1      asynchronous active-low reset
//   start       in  1      request, sampled only in IDLE
//   a, b        in  WIDTH  dividend / divisor, captured on accepted start
//   busy        out 1      high while iterating
//   done        out 1      one-cycle pulse, results valid
//   q, r        out WIDTH  quotient / remainder, held until next completion
//   div_by_zero out 1      last completed operation had b == 0
module divider_8x8_seq
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             div_by_zero
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] DBZ_Q    = WIDTH'(dbz_quotient(WIDTH));

   state_t            state_reg, state_next;
   // Dividend bits leave at the MSB while quotient bits enter at the LSB,
   // so after WIDTH iterations this register holds the quotient.
   logic [WIDTH-1:0]  dividend_reg, dividend_next;
   logic [WIDTH-1:0]  divisor_reg, divisor_next;
   logic [WIDTH-1:0]  rem_reg, rem_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [WIDTH-1:0]  q_reg, q_next;
   logic [WIDTH-1:0]  r_reg, r_next;
   logic              dbz_reg, dbz_next;
   logic              done_reg, done_next;

   logic [WIDTH-1:0]  step_rem;
   logic              step_bit;

   divider_step #(.WIDTH(WIDTH)) u_step (
      .rem          (rem_reg),
      .dividend_msb (dividend_reg[WIDTH-1]),
      .divisor      (divisor_reg),
      .rem_next     (step_rem),
      .q_bit        (step_bit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         dividend_reg <= '0;
         divisor_reg  <= '0;
         rem_reg      <= '0;
         cnt_reg      <= '0;
         q_reg        <= '0;
         r_reg        <= '0;
         dbz_reg      <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         dividend_reg <= dividend_next;
         divisor_reg  <= divisor_next;
         rem_reg      <= rem_next;
         cnt_reg      <= cnt_next;
         q_reg        <= q_next;
         r_reg        <= r_next;
         dbz_reg      <= dbz_next;
         done_reg     <= done_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      dividend_next = dividend_reg;
      divisor_next  = divisor_reg;
      rem_next      = rem_reg;
      cnt_next      = cnt_reg;
      q_next        = q_reg;
      r_next        = r_reg;
      dbz_next      = dbz_reg;
      done_next     = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start) begin
               if (b != '0) begin
                  dividend_next = a;
                  divisor_next  = b;
                  rem_next      = '0;
                  cnt_next      = '0;
                  state_next    = RUN;
               end else begin
                  // Divide by zero completes immediately without iterating.
                  done_next = 1'b1;
                  dbz_next  = 1'b1;
                  q_next    = DBZ_Q;
                  r_next    = a;
               end
            end
         end
         RUN: begin
            dividend_next = {dividend_reg[WIDTH-2:0], step_bit};
            rem_next      = step_rem;
            cnt_next      = cnt_reg + CNT_W'(1);
            if (cnt_reg == LAST_CNT) begin
               q_next     = {dividend_reg[WIDTH-2:0], step_bit};
               r_next     = step_rem;
               dbz_next   = 1'b0;
               done_next  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy        = (state_reg == RUN);
   assign done        = done_reg;
   assign q           = q_reg;
   assign r           = r_reg;
   assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_divider_8x8_seq.sv
// Directed and random checks for divider_8x8_seq (WIDTH = 8).
module tb_divider_8x8_seq;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       busy;
   logic       done;
   logic [7:0] q;
   logic [7:0] r;
   logic       div_by_zero;

   int checks;
   int errors;

   divider_8x8_seq dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .q           (q),
      .r           (r),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one request and wait for done. Called just after a clock edge.
   // edges = clock edges after the accepting edge until done is visible.
   task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                         output int edges, output int busy_cnt);
      start = 1'b1;
      a = ia;
      b = ib;
      @(posedge clk); #1;
      start = 1'b0;
      edges = 0;
      busy_cnt = 0;
      while (!done && edges < 40) begin
         if (busy) busy_cnt++;
         @(posedge clk); #1;
         edges++;
      end
   endtask

   task automatic test_reset();
      checks++;
      if ({busy, done, q, r, div_by_zero} !== 19'd0) begin
         errors++;
         $display("FAIL reset_state: busy=%b done=%b q=%0d r=%0d dbz=%b, required all zero",
                  busy, done, q, r, div_by_zero);
      end
   endtask

   task automatic test_basic();
      int edges, bc;
      run_op(8'd200, 8'd7, edges, bc);
      checks++;
      if (q !== 8'd28 || r !== 8'd4 || div_by_zero !== 1'b0 || done !== 1'b1) begin
         errors++;
         $display("FAIL basic_200_7: q=%0d r=%0d dbz=%b done=%b, required q=28 r=4 dbz=0 done=1",
                  q, r, div_by_zero, done);
      end
      checks++;
      if (edges != 8 || bc != 8) begin
         errors++;
         $display("FAIL basic_latency: edges=%0d busy_cycles=%0d, required 8 and 8", edges, bc);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || q !== 8'd28) begin
         errors++;
         $display("FAIL done_pulse: done=%b q=%0d, required done=0 q=28", done, q);
      end
   endtask

   // Outputs from the previous completion stay put while the next runs.
   task automatic test_hold();
      int n;
      int bad;
      start = 1'b1; a = 8'd9; b = 8'd2;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      bad = 0;
      while (!done && n < 40) begin
         if (q !== 8'd28 || r !== 8'd4) bad++;
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL hold_outputs: %0d cycles changed early, required 0", bad);
      end
      checks++;
      if (q !== 8'd4 || r !== 8'd1 || n != 8) begin
         errors++;
         $display("FAIL hold_result_9_2: q=%0d r=%0d edges=%0d, required q=4 r=1 edges=8", q, r, n);
      end
   endtask

   task automatic test_corners();
      int ca[5] = '{0, 5, 255, 255, 128};
      int cb[5] = '{5, 9, 1, 255, 128};
      int eq[5] = '{0, 0, 255, 1, 1};
      int er[5] = '{0, 5, 0, 0, 0};
      int edges, bc;
      for (int i = 0; i < 5; i++) begin
         run_op(8'(ca[i]), 8'(cb[i]), edges, bc);
         checks++;
         if (q !== 8'(eq[i]) || r !== 8'(er[i]) || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL corner_%0d_%0d: q=%0d r=%0d dbz=%b, required q=%0d r=%0d dbz=0",
                     ca[i], cb[i], q, r, div_by_zero, eq[i], er[i]);
         end
      end
   endtask

   task automatic test_div_by_zero();
      int edges, bc;
      run_op(8'd77, 8'd0, edges, bc);
      checks++;
      if (q !== 8'd255 || r !== 8'd77 || div_by_zero !== 1'b1 || edges != 0 || bc != 0) begin
         errors++;
         $display("FAIL dbz_77_0: q=%0d r=%0d dbz=%b edges=%0d busy_cycles=%0d, required 255 77 1 0 0",
                  q, r, div_by_zero, edges, bc);
      end
      run_op(8'd10, 8'd3, edges, bc);
      checks++;
      if (q !== 8'd3 || r !== 8'd1 || div_by_zero !== 1'b0) begin
         errors++;
         $display("FAIL dbz_clear_10_3: q=%0d r=%0d dbz=%b, required q=3 r=1 dbz=0",
                  q, r, div_by_zero);
      end
   endtask

   task automatic test_ignore_start();
      int n;
      start = 1'b1; a = 8'd100; b = 8'd9;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (!done && n < 40) begin
         if (n == 3) begin
            start = 1'b1; a = 8'd50; b = 8'd5;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0;
      checks++;
      if (q !== 8'd11 || r !== 8'd1 || n != 8) begin
         errors++;
         $display("FAIL ignore_start: q=%0d r=%0d edges=%0d, required q=11 r=1 edges=8", q, r, n);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      start = 1'b1; a = 8'd100; b = 8'd10;
      @(posedge clk); #1;
      n = 0;
      while (!done && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (q !== 8'd10 || r !== 8'd0 || n != 8) begin
         errors++;
         $display("FAIL b2b_first: q=%0d r=%0d edges=%0d, required q=10 r=0 edges=8", q, r, n);
      end
      // Still holding start: the next edge (done cycle, IDLE) accepts 99/10.
      a = 8'd99; b = 8'd10;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL b2b_accept: busy=%b done=%b, required busy=1 done=0", busy, done);
      end
      n = 0;
      while (!done && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (q !== 8'd9 || r !== 8'd9 || n != 8) begin
         errors++;
         $display("FAIL b2b_second: q=%0d r=%0d edges=%0d, required q=9 r=9 edges=8", q, r, n);
      end
   endtask

   task automatic test_reset_mid_run();
      int edges, bc;
      int seen_done;
      start = 1'b1; a = 8'd200; b = 8'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, q, r, div_by_zero} !== 19'd0) begin
         errors++;
         $display("FAIL reset_mid_run: busy=%b done=%b q=%0d r=%0d dbz=%b, required all zero",
                  busy, done, q, r, div_by_zero);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      seen_done = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done || busy) seen_done++;
      end
      checks++;
      if (seen_done != 0) begin
         errors++;
         $display("FAIL reset_no_done: %0d cycles with done/busy, required 0", seen_done);
      end
      run_op(8'd9, 8'd2, edges, bc);
      checks++;
      if (q !== 8'd4 || r !== 8'd1 || div_by_zero !== 1'b0) begin
         errors++;
         $display("FAIL after_reset_9_2: q=%0d r=%0d dbz=%b, required q=4 r=1 dbz=0",
                  q, r, div_by_zero);
      end
   endtask

   task automatic test_random();
      int edges, bc;
      logic [7:0] ra, rb, recon;
      for (int i = 0; i < 2000; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(1, 255));
         run_op(ra, rb, edges, bc);
         recon = 8'(q * rb + r);
         checks++;
         if (recon !== ra || r >= rb || q !== ra / rb || r !== ra % rb) begin
            errors++;
            $display("FAIL random_%0d_%0d: q=%0d r=%0d, required q=%0d r=%0d",
                     ra, rb, q, r, ra / rb, ra % rb);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      start = 1'b0;
      a = '0;
      b = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      test_reset();
      test_basic();
      test_hold();
      test_corners();
      test_div_by_zero();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid_run();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
